// File: rtl/char_pkg.sv
// Shared constants and types for the text-mode pixel generator.
package char_pkg;
    localparam int CELL_W = 16;
    localparam int CELL_H = 16;
    localparam int ROM_AW = 11;
    localparam int ROM_DW = 16;
    localparam int LAT    = 4;

    typedef logic [15:0] rgb565_t;

    // Sync/active flags that travel alongside the pixel path.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    // After the text-buffer address is issued.
    typedef struct packed {
        logic [3:0] px;
        logic [3:0] py;
        logic       in_grid;
        logic       cur;
    } s1_t;

    // After the glyph-row address is issued.
    typedef struct packed {
        logic [3:0] px;
        logic       inv;
        logic       in_grid;
        logic       cur;
    } s2_t;

    // After the glyph bit has been selected.
    typedef struct packed {
        logic pix;
        logic inv;
        logic in_grid;
        logic cur;
    } s3_t;
endpackage

// File: rtl/cursor_blink.sv
// Cursor blink: vsync rising-edge frame counter and cursor cell compare.
// Only built when CHAR_CURSOR_EN is defined.
`ifdef CHAR_CURSOR_EN
module cursor_blink (
    input  logic       pix_clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic [6:0] col,
    input  logic [6:0] row,
    input  logic [5:0] cursor_col,
    input  logic [4:0] cursor_row,
    output logic       hit
);
    logic       vs_d, vs_q;
    logic [5:0] cnt_d, cnt_q;

    // Count frames on vsync rising edges; hit while counter is in its lower half.
    always_comb begin
        vs_d  = vsync_in;
        cnt_d = cnt_q;
        if (vsync_in && !vs_q) cnt_d = cnt_q + 6'd1;
        hit = (col == {1'b0, cursor_col}) && (row == {2'b00, cursor_row}) && !cnt_q[5];
    end

    // Edge-detect and counter registers.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            vs_q  <= vs_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/char_pixel_gen.sv
// Text-mode pixel generator: pixel position -> text buffer -> glyph ROM -> RGB565.
// Four-stage pipeline; define CHAR_CURSOR_EN to add the blinking cursor.
import char_pkg::*;

module char_pixel_gen #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic                pix_clk,
    input  logic                rst,
    input  logic [10:0]         hcount,
    input  logic [10:0]         vcount,
    input  logic                active_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    output logic [ROM_AW-1:0]   text_addr,
    input  logic [7:0]          text_char,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [ROM_DW-1:0]   rom_do,
    input  logic [15:0]         fg_color,
    input  logic [15:0]         bg_color,
    input  logic [5:0]          cursor_col,
    input  logic [4:0]          cursor_row,
    output logic [15:0]         rgb,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                active_out
);
    localparam logic [17:0] COLS_W = 18'(COLS);

    logic [6:0]  col, row;
    logic        in_grid, cursor_hit, on;
    logic [17:0] addr_full;

    logic [ROM_AW-1:0]     text_addr_d, text_addr_q;
    logic [ROM_AW-1:0]     rom_addr_d, rom_addr_q;
    rgb565_t               rgb_d, rgb_q;
    s1_t                   s1_d, s1_q;
    s2_t                   s2_d, s2_q;
    s3_t                   s3_d, s3_q;
    sync_t [LAT-1:0]       sync_d, sync_q;

    assign col = hcount[10:4];
    assign row = vcount[10:4];

`ifdef CHAR_CURSOR_EN
    cursor_blink u_blink (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .col        (col),
        .row        (row),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .hit        (cursor_hit)
    );
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_col, cursor_row};
    assign cursor_hit    = 1'b0;
`endif

    // Next-state for every pipeline stage; external memories answer one cycle after each address.
    always_comb begin
        in_grid     = (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
        addr_full   = 18'(row) * COLS_W + 18'(col);
        text_addr_d = in_grid ? addr_full[ROM_AW-1:0] : '0;
        s1_d        = '{px: hcount[3:0], py: vcount[3:0], in_grid: in_grid, cur: cursor_hit};

        rom_addr_d  = {text_char[6:0], s1_q.py};
        s2_d        = '{px: s1_q.px, inv: text_char[7], in_grid: s1_q.in_grid, cur: s1_q.cur};

        // bit15 is the leftmost pixel, so index 15-px, which is ~px on 4 bits.
        s3_d        = '{pix: rom_do[~s2_q.px], inv: s2_q.inv, in_grid: s2_q.in_grid, cur: s2_q.cur};

        on    = s3_q.pix ^ s3_q.inv ^ s3_q.cur;
        rgb_d = !sync_q[LAT-2].active ? '0 :
                !s3_q.in_grid         ? bg_color :
                on                    ? fg_color : bg_color;

        sync_d = {sync_q[LAT-2:0], sync_t'{active: active_in, hsync: hsync_in, vsync: vsync_in}};
    end

    // Pipeline registers.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            text_addr_q <= '0;
            rom_addr_q  <= '0;
            rgb_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            sync_q      <= '0;
        end else begin
            text_addr_q <= text_addr_d;
            rom_addr_q  <= rom_addr_d;
            rgb_q       <= rgb_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            sync_q      <= sync_d;
        end
    end

    assign text_addr  = text_addr_q;
    assign rom_addr   = rom_addr_q;
    assign rgb        = rgb_q;
    assign hsync_out  = sync_q[LAT-1].hsync;
    assign vsync_out  = sync_q[LAT-1].vsync;
    assign active_out = sync_q[LAT-1].active;
endmodule
